alu_seq_ctrl: RTL and testbench

Multi-cycle ALU sequencer for the RV32I core's execute stage. It accepts one operation per start pulse, encoded in the 4-bit ALU control code the ALU control decoder already produces. Non-shift operations complete in one cycle. Shifts run one bit per cycle on an internal accumulator, which removes the barrel shifter from the critical path. It raises `busy_o` so the pipeline can stall, and pulses `done_o` with a registered result.

---
 rtl/alu_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU sequencer: single-cycle logic/arithmetic ops, shifts iterated one bit per cycle.
// busy_o stalls the pipeline while a shift runs; done_o pulses with the registered result.
module alu_seq_ctrl #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [3:0]      ctrl_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            illegal_o
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    typedef enum logic [1:0] {
        SH_LL,
        SH_RL,
        SH_RA
    } shop_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_SLL = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;

    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

    state_t            state_q, state_d;
    shop_t             shop_q, shop_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              done_q, done_d;
    logic              illegal_q, illegal_d;
    logic [XLEN-1:0]   shifted;
    logic [SHW-1:0]    shamt;

    assign shamt = b_i[SHW-1:0];

    // One-bit step of the accumulator; SRA replicates the MSB, which still holds the original sign.
    always_comb begin
        shifted = acc_q;
        case (shop_q)
            SH_LL:   shifted = {acc_q[XLEN-2:0], 1'b0};
            SH_RL:   shifted = {1'b0, acc_q[XLEN-1:1]};
            SH_RA:   shifted = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
            default: shifted = acc_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        shop_d    = shop_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    done_d = 1'b1;
                    case (ctrl_i)
                        OP_ADD: result_d = a_i + b_i;
                        OP_SUB: result_d = a_i - b_i;
                        OP_XOR: result_d = a_i ^ b_i;
                        OP_OR:  result_d = a_i | b_i;
                        OP_AND: result_d = a_i & b_i;
                        OP_SLL, OP_SRL, OP_SRA: begin
                            // A zero shift amount completes immediately with the operand unchanged.
                            if (shamt == '0) begin
                                result_d = a_i;
                            end else begin
                                done_d  = 1'b0;
                                acc_d   = a_i;
                                cnt_d   = shamt;
                                state_d = SHIFT;
                                if (ctrl_i == OP_SLL)
                                    shop_d = SH_LL;
                                else if (ctrl_i == OP_SRL)
                                    shop_d = SH_RL;
                                else
                                    shop_d = SH_RA;
                            end
                        end
                        default: begin
                            result_d  = '0;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            SHIFT: begin
                acc_d = shifted;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    result_d = shifted;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shop_q    <= SH_LL;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shop_q    <= shop_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy_o    = (state_q == SHIFT);
    assign done_o    = done_q;
    assign illegal_o = illegal_q;
    assign result_o  = result_q;
    assign zero_o    = (result_q == '0);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: a cycle-level reference model queues expected results at
// acceptance, and a negedge monitor pops and compares them whenever done_o is presented.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [3:0]  ctrl_i = 4'd0;
    logic [31:0] a_i = 32'd0;
    logic [31:0] b_i = 32'd0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        zero_o;
    logic        illegal_o;

    typedef struct packed {
        logic [31:0] res;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    int          busy_left = 0;
    bit          exp_done = 1'b0;
    bit          accepted = 1'b0;
    logic [31:0] last_res = 32'd0;
    logic [31:0] m_r;
    logic        m_ill;
    int          m_lat;
    int          total = 0;
    int          bad = 0;

    alu_seq_ctrl #(.XLEN(32), .SHW(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_i   (start_i),
        .ctrl_i    (ctrl_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .zero_o    (zero_o),
        .illegal_o (illegal_o)
    );

    always #5 clk = ~clk;

    function automatic void ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic ill, output int lat);
        logic [4:0] sh;
        sh  = b[4:0];
        r   = 32'd0;
        ill = 1'b0;
        lat = 0;
        case (c)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: begin r = a << sh; lat = int'(sh); end
            4'd3: r = a ^ b;
            4'd4: begin r = a >> sh; lat = int'(sh); end
            4'd5: begin r = $unsigned($signed(a) >>> sh); lat = int'(sh); end
            4'd6: r = a | b;
            4'd7: r = a & b;
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: decides acceptance and completion timing from the op rules alone.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            busy_left = 0;
            exp_done  = 1'b0;
            accepted  = 1'b0;
            last_res  = 32'd0;
        end else begin
            exp_done = 1'b0;
            accepted = 1'b0;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0)
                    exp_done = 1'b1;
            end else if (start_i) begin
                accepted = 1'b1;
                ref_op(ctrl_i, a_i, b_i, m_r, m_ill, m_lat);
                exp_q.push_back('{res: m_r, ill: m_ill});
                if (m_lat == 0)
                    exp_done = 1'b1;
                else
                    busy_left = m_lat;
            end
        end
    end

    task automatic check_output();
        exp_t e;
        check_val("busy", 32'(busy_o), 32'(busy_left > 0));
        check_val("done", 32'(done_o), 32'(exp_done));
        if (done_o) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL scoreboard_empty actual=done expected=no_done at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                last_res = e.res;
                check_val("result", result_o, e.res);
                check_val("illegal", 32'(illegal_o), 32'(e.ill));
                check_val("zero", 32'(zero_o), 32'(e.res == 32'd0));
            end
        end else begin
            check_val("illegal_idle", 32'(illegal_o), 32'd0);
            check_val("result_hold", result_o, last_res);
            check_val("zero_hold", 32'(zero_o), 32'(last_res == 32'd0));
        end
    endtask

    always @(negedge clk) begin
        if (!reset)
            check_output();
    end

    // Holds the request until the model reports acceptance, so it also exercises start during busy.
    task automatic apply_stimulus(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        ctrl_i  = c;
        a_i     = a;
        b_i     = b;
        start_i = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(posedge clk);
            #1;
            if (accepted)
                return;
        end
        total++;
        bad++;
        $display("[TB] FAIL accept_timeout actual=not_accepted expected=accepted at %0t", $time);
        start_i = 1'b0;
    endtask

    task automatic idle(input int n);
        start_i = 1'b0;
        ctrl_i  = 4'($urandom);
        a_i     = $urandom;
        b_i     = $urandom;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic count_busy(input int expected, input string name);
        int n;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy_o)
                n++;
            else
                break;
        end
        check_val(name, 32'(n), 32'(expected));
    endtask

    initial begin
        int          sel;
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("rst_busy", 32'(busy_o), 32'd0);
        check_val("rst_done", 32'(done_o), 32'd0);
        check_val("rst_result", result_o, 32'd0);
        check_val("rst_zero", 32'(zero_o), 32'd1);

        apply_stimulus(4'd0, 32'hFFFF_FFFF, 32'h1);
        check_val("add_wrap", result_o, 32'h0);
        apply_stimulus(4'd1, 32'd5, 32'd7);
        check_val("sub_neg", result_o, 32'hFFFF_FFFE);
        idle(1);

        apply_stimulus(4'd2, 32'h1, 32'd5);
        start_i = 1'b0;
        count_busy(5, "sll5_busy_cycles");
        #1;
        check_val("sll5_result", result_o, 32'h20);
        idle(1);

        apply_stimulus(4'd5, 32'h8000_0000, 32'd31);
        start_i = 1'b0;
        count_busy(31, "sra31_busy_cycles");
        #1;
        check_val("sra31_result", result_o, 32'hFFFF_FFFF);
        idle(1);

        apply_stimulus(4'd4, 32'hF0, 32'd4);
        apply_stimulus(4'd0, 32'd3, 32'd4);
        start_i = 1'b0;
        check_val("held_add_result", result_o, 32'd7);
        check_val("held_add_done", 32'(done_o), 32'd1);
        idle(2);

        apply_stimulus(4'b1010, 32'h1234_5678, 32'h9ABC_DEF0);
        start_i = 1'b0;
        check_val("illegal_flag", 32'(illegal_o), 32'd1);
        check_val("illegal_done", 32'(done_o), 32'd1);
        check_val("illegal_result", result_o, 32'd0);
        idle(2);

        apply_stimulus(4'd0, 32'd40, 32'd2);
        apply_stimulus(4'd2, 32'h1, 32'd10);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_val("midrst_busy", 32'(busy_o), 32'd0);
        check_val("midrst_done", 32'(done_o), 32'd0);
        check_val("midrst_result", result_o, 32'd0);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        idle(15);

        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 8)
                c = 4'(sel);
            else
                c = 4'(8 + $urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0)
                b[4:0] = 5'd0;
            if ($urandom_range(0, 3) == 0)
                a[31] = 1'b1;
            apply_stimulus(c, a, b);
            if ($urandom_range(0, 2) == 0)
                idle($urandom_range(1, 3));
        end

        start_i = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (busy_left == 0 && exp_q.size() == 0)
                break;
        end
        check_val("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
